// File: rtl/fifo_pkg.sv
// ============================================================================
// Package     : fifo_pkg
// Description : Types and defaults shared by the byte-in/word-out FIFO and
//               its downstream word unpacker. Holds the unpacker FSM state
//               encoding, the default word/byte widths and a small helper
//               that sizes the byte index counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    // Default widths, shared with the FIFO block so both ends agree
    localparam int DEF_WORD_W = 32;
    localparam int DEF_BYTE_W = 8;

    // Unpacker FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } unpack_state_t;

    // Width of a counter indexing nbytes items; never narrower than one bit
    // so a single-byte word still gets a legal vector.
    function automatic int idx_width(input int nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/unpack_shift_reg.sv
// ============================================================================
// Module      : unpack_shift_reg
// Description : Load/shift register that serialises one FIFO word into bytes.
//               A load captures a full word; each shift steps to the next
//               byte. The current byte is always presented on byte_out.
//               MSB_FIRST=0 presents the low byte and shifts right;
//               MSB_FIRST=1 presents the top byte and shifts left.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unpack_shift_reg
    import fifo_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int BYTE_W    = DEF_BYTE_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              shift,
    output logic [BYTE_W-1:0] byte_out
);

    logic [WORD_W-1:0] r_sr;

    generate
        if (MSB_FIRST) begin : g_msb_first
            // Capture a new word, or move the next-lower byte into the top slot
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_sr <= '0;
                end else if (load) begin
                    r_sr <= load_data;
                end else if (shift) begin
                    r_sr <= r_sr << BYTE_W;
                end
            end

            assign byte_out = r_sr[WORD_W-1 -: BYTE_W];
        end else begin : g_lsb_first
            // Capture a new word, or move the next-higher byte into the bottom slot
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_sr <= '0;
                end else if (load) begin
                    r_sr <= load_data;
                end else if (shift) begin
                    r_sr <= r_sr >> BYTE_W;
                end
            end

            assign byte_out = r_sr[BYTE_W-1:0];
        end
    endgenerate

endmodule : unpack_shift_reg

`default_nettype wire

// File: rtl/fifo_word_unpacker.sv
// ============================================================================
// Module      : fifo_word_unpacker
// Description : Pops WORD_W-bit words from a FIFO whenever it is non-empty
//               and emits each as WORD_W/BYTE_W bytes on a valid/ready byte
//               stream, flagging the final byte of every word with m_last.
//               Owns the FIFO read strobe and never reads an empty FIFO.
//               Optional macro UNPACK_PARITY_EN adds an even-parity output
//               m_parity that accompanies m_data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_word_unpacker
    import fifo_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int BYTE_W    = DEF_BYTE_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fifo_empty,
    output logic              fifo_rn,
    input  logic [WORD_W-1:0] fifo_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [BYTE_W-1:0] m_data,
    output logic              m_last,
    output logic              busy
`ifdef UNPACK_PARITY_EN
    ,
    output logic              m_parity
`endif
);

    localparam int               NBYTES   = WORD_W / BYTE_W;
    localparam int               IDX_W    = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    unpack_state_t     r_state;
    logic [IDX_W-1:0]  r_index;
    logic              r_valid;
    logic              r_last;
    logic              r_busy;

    logic              w_hs;
    logic              w_last_hs;
    logic              w_load;
    logic              w_shift;
    logic [BYTE_W-1:0] w_byte;

    // A byte is transferred when it is offered and downstream takes it;
    // m_ready on its own means nothing while nothing is offered.
    assign w_hs      = r_valid & m_ready;
    assign w_last_hs = w_hs & (r_index == LAST_IDX);

    // Read strobe: from IDLE as soon as data exists, or chained onto the
    // last-byte handshake so consecutive words lose only the LOAD cycle.
    // Gated by reset so the FIFO is never popped while the block is held.
    assign fifo_rn = reset & ~fifo_empty & ((r_state == ST_IDLE) | w_last_hs);

    // The FIFO presents read data in the cycle after the strobe, which is
    // exactly the LOAD cycle.
    assign w_load  = (r_state == ST_LOAD);

    // Advance the byte on every handshake except the last; the register
    // is reloaded before it would be used again.
    assign w_shift = w_hs & ~w_last_hs;

    unpack_shift_reg #(
        .WORD_W    (WORD_W),
        .BYTE_W    (BYTE_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clock     (clock),
        .reset     (reset),
        .load      (w_load),
        .load_data (fifo_dout),
        .shift     (w_shift),
        .byte_out  (w_byte)
    );

    // Control FSM: sequences read, load and byte send, and keeps the
    // stream-side flags registered alongside the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_index <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    r_state <= ST_SEND;
                    r_index <= '0;
                    r_valid <= 1'b1;
                    r_last  <= (LAST_IDX == '0);
                end

                ST_SEND: begin
                    // Without a handshake everything holds, which keeps
                    // m_data and m_last stable under backpressure.
                    if (m_ready) begin
                        if (r_index == LAST_IDX) begin
                            r_index <= '0;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            if (!fifo_empty) begin
                                r_state <= ST_LOAD;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_index <= r_index + ONE_IDX;
                            r_last  <= ((r_index + ONE_IDX) == LAST_IDX);
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_index <= '0;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign m_valid = r_valid;
    assign m_last  = r_last;
    assign busy    = r_busy;
    assign m_data  = w_byte;

`ifdef UNPACK_PARITY_EN
    // Even parity of the byte on m_data; follows the registered byte, so it
    // holds under backpressure and is 0 out of reset.
    assign m_parity = ^w_byte;
`endif

endmodule : fifo_word_unpacker

`default_nettype wire

// File: tb/tb_fifo_word_unpacker.sv
// ============================================================================
// Module      : tb_fifo_word_unpacker
// Description : Self-checking bench for fifo_word_unpacker. Two instances
//               (LSB-first and MSB-first) share one FIFO model and one
//               downstream ready; each has its own expected-byte queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_word_unpacker;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        fifo_empty;
    logic [31:0] fifo_dout;
    logic        m_ready;

    logic        rn0, rn1, v0, v1, l0, l1, b0, b1;
    logic [7:0]  d0, d1;
`ifdef UNPACK_PARITY_EN
    logic        p0, p1;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rn_cnt = 0;
    int          stall_left = 0;
    logic        prev_rn = 1'b0;

    logic [31:0] fifo_q[$];
    exp_t        exp0[$];
    exp_t        exp1[$];
    int          rn_cyc[$];
    int          hs_cyc[$];
    logic [7:0]  hs_data[$];

    fifo_word_unpacker #(.WORD_W(32), .BYTE_W(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clock      (clock),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_rn    (rn0),
        .fifo_dout  (fifo_dout),
        .m_valid    (v0),
        .m_ready    (m_ready),
        .m_data     (d0),
        .m_last     (l0),
        .busy       (b0)
`ifdef UNPACK_PARITY_EN
        ,
        .m_parity   (p0)
`endif
    );

    fifo_word_unpacker #(.WORD_W(32), .BYTE_W(8), .MSB_FIRST(1'b1)) dut_msb (
        .clock      (clock),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_rn    (rn1),
        .fifo_dout  (fifo_dout),
        .m_valid    (v1),
        .m_ready    (m_ready),
        .m_data     (d1),
        .m_last     (l1),
        .busy       (b1)
`ifdef UNPACK_PARITY_EN
        ,
        .m_parity   (p1)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case something wedges the directed sequence
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_t e;
        fifo_q.push_back(w);
        for (int i = 0; i < 4; i++) begin
            e.data = w[8*i +: 8];
            e.last = (i == 3);
            exp0.push_back(e);
            e.data = w[8*(3-i) +: 8];
            exp1.push_back(e);
        end
    endtask

    task automatic clear_logs();
        rn_cyc.delete();
        hs_cyc.delete();
        hs_data.delete();
    endtask

    task automatic monitor();
        exp_t e0, e1;
        check("rn_agree", {31'd0, rn1}, {31'd0, rn0});
        check("valid_agree", {31'd0, v1}, {31'd0, v0});
        check("rn_while_empty", {31'd0, rn0 & fifo_empty}, 32'd0);
        check("rn_twice", {31'd0, rn0 & prev_rn}, 32'd0);
        if (rn0) begin
            rn_cnt++;
            rn_cyc.push_back(cyc);
        end
        if (v0 && m_ready) begin
            check("sb_nonempty", {31'd0, (exp0.size() > 0) && (exp1.size() > 0)}, 32'd1);
            if (exp0.size() > 0 && exp1.size() > 0) begin
                e0 = exp0.pop_front();
                e1 = exp1.pop_front();
                check("lsb_data", {24'd0, d0}, {24'd0, e0.data});
                check("lsb_last", {31'd0, l0}, {31'd0, e0.last});
                check("msb_data", {24'd0, d1}, {24'd0, e1.data});
                check("msb_last", {31'd0, l1}, {31'd0, e1.last});
`ifdef UNPACK_PARITY_EN
                check("lsb_parity", {31'd0, p0}, {31'd0, ^e0.data});
                check("msb_parity", {31'd0, p1}, {31'd0, ^e1.data});
`endif
            end
            hs_cyc.push_back(cyc);
            hs_data.push_back(d0);
        end
    endtask

    // One clock: apply the FIFO pop from the previous edge, drive ready,
    // then sample outputs mid-low-phase.
    task automatic step();
        @(negedge clock);
        cyc++;
        if (prev_rn && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        if (stall_left > 0) begin
            m_ready = 1'b0;
            stall_left--;
        end else begin
            m_ready = 1'b1;
        end
        #1;
        monitor();
        prev_rn = rn0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (n < 200 && !(exp0.size() == 0 && fifo_q.size() == 0 && !b0)) begin
            step();
            n++;
        end
        check("drain_left", exp0.size(), 32'd0);
        step();
    endtask

    task automatic wait_hs(input int count);
        int n;
        n = 0;
        while (n < 50 && hs_cyc.size() < count) begin
            step();
            n++;
        end
        check("wait_hs", hs_cyc.size(), count);
    endtask

    initial begin
        reset      = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = 32'd0;
        m_ready    = 1'b0;

        // Reset values
        #3;
        check("rst_valid", {31'd0, v0 | v1}, 32'd0);
        check("rst_data", {16'd0, d0, d1}, 32'd0);
        check("rst_last", {31'd0, l0 | l1}, 32'd0);
        check("rst_busy", {31'd0, b0 | b1}, 32'd0);
        check("rst_rn", {31'd0, rn0 | rn1}, 32'd0);
        step();
        step();
        reset = 1'b1;

        // Single word, ready always high
        clear_logs();
        push_word(32'hA1B2C3D4);
        drain();
        check("t1_rn_count", rn_cyc.size(), 32'd1);
        check("t1_hs_count", hs_cyc.size(), 32'd4);
        if (rn_cyc.size() == 1 && hs_cyc.size() == 4) begin
            check("t1_first_lat", hs_cyc[0], rn_cyc[0] + 2);
            check("t1_last_lat", hs_cyc[3], rn_cyc[0] + 5);
        end

        // Backpressure on byte 1
        clear_logs();
        push_word(32'hA1B2C3D4);
        wait_hs(1);
        stall_left = 3;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_valid_hold", {31'd0, v0}, 32'd1);
            check("t2_lsb_hold", {24'd0, d0}, 32'h0000_00C3);
            check("t2_msb_hold", {24'd0, d1}, 32'h0000_00B2);
            check("t2_last_hold", {31'd0, l0}, 32'd0);
        end
        drain();
        check("t2_hs_count", hs_cyc.size(), 32'd4);
        if (hs_cyc.size() == 4) check("t2_stall_gap", hs_cyc[1], hs_cyc[0] + 4);

        // Back-to-back words
        clear_logs();
        push_word(32'h11223344);
        push_word(32'h55667788);
        drain();
        check("t3_rn_count", rn_cyc.size(), 32'd2);
        check("t3_hs_count", hs_cyc.size(), 32'd8);
        if (rn_cyc.size() == 2 && hs_cyc.size() == 8) begin
            check("t3_rn_on_last", rn_cyc[1], hs_cyc[3]);
            check("t3_bubble", hs_cyc[4], hs_cyc[3] + 2);
            check("t3_second_first", {24'd0, hs_data[4]}, 32'h0000_0088);
        end

        // Empty FIFO: nothing moves
        for (int i = 0; i < 20; i++) begin
            step();
            check("t4_idle", {29'd0, v0, b0, rn0}, 32'd0);
        end

        // Asynchronous reset mid-word
        clear_logs();
        push_word(32'hCAFEF00D);
        wait_hs(2);
        #2;
        reset = 1'b0;
        #1;
        check("t5_valid", {31'd0, v0 | v1}, 32'd0);
        check("t5_data", {16'd0, d0, d1}, 32'd0);
        check("t5_last_busy", {30'd0, l0 | l1, b0 | b1}, 32'd0);
        check("t5_rn", {31'd0, rn0}, 32'd0);
        exp0.delete();
        exp1.delete();
        prev_rn = 1'b0;
        step();
        step();
        reset = 1'b1;
        clear_logs();
        push_word(32'h0BADBEEF);
        drain();
        check("t5_hs_count", hs_cyc.size(), 32'd4);
        if (hs_cyc.size() == 4) check("t5_restart_byte0", {24'd0, hs_data[0]}, 32'h0000_00EF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fifo_word_unpacker

`default_nettype wire
